// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, no parity, one stop bit.
// Mid-bit sampling from a falling start edge, one-deep holding register
// with ready/valid hand-off, and single-cycle frame/overrun error pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_s_d;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             fall;
  logic             sample;
  logic             stop_good;
  logic             stop_bad;

  // Two-flop synchronizer plus one-cycle delayed copy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, sample strobe and stop-bit decode
  always_comb begin
    state_next = state;
    sample     = 1'b0;
    fall       = rx_s_d & ~rx_s;
    case (state)
      IDLE: begin
        if (fall) state_next = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          sample     = 1'b1;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          sample = 1'b1;
          if (bit_cnt == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          sample     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    stop_good = (state == STOP) && sample && rx_s;
    stop_bad  = (state == STOP) && sample && !rx_s;
    busy      = (state != IDLE);
  end

  // Bit-period counter: restarts on every sample and every state change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state == IDLE || sample || state_next != state) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Data shift register and bit index, LSB arrives first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (state == START && sample) begin
      bit_cnt <= '0;
    end else if (state == DATA && sample) begin
      shift   <= {rx_s, shift[7:1]};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Holding register hand-off and error pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= stop_good && valid && !ready;
      if (stop_good && (!valid || ready)) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
